conv_result_writer: RTL
=======================

Name: conv_result_writer

Overview:
- Write-side counterpart of the conv data mover: it drains systolic-array (SA) result rows back into an output BRAM (mem2), where the mover only reads mem0/mem1.
- SA results leave the array diagonally skewed (lane i is i cycles behind lane 0). This block de-skews them, optionally applies ReLU, and writes one PE_SIZE-lane row per mem2 address.
- Rows are counted per output tile; a done pulse is raised after TILE_NUM tiles.

Parameters:
- PE_SIZE, 16: number of SA lanes.
- DATA_WIDTH, 8: bits per lane, two's-complement.
- ROW_NUM, 64: rows per tile.
- TILE_NUM, 14: tiles per layer.
- MEM2_DEPTH, 896: mem2 word count (default = ROW_NUM*TILE_NUM).
- MEM2_ADDR_WIDTH, 10: mem2 address width.
- RELU_EN, 1: when 1, a negative lane is written as 0.
- Derived: MEM2_DATA_WIDTH = PE_SIZE*DATA_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle pulse; begins a layer.
- sa_result_i  in  MEM2_DATA_WIDTH  skewed SA results; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- sa_valid_i  in  PE_SIZE  per-lane valid, skewed the same way as the data.
- mem2_addr0  out  MEM2_ADDR_WIDTH  write address.
- mem2_ce0  out  1  chip enable.
- mem2_we0  out  1  write enable.
- mem2_d0  out  MEM2_DATA_WIDTH  write data.
- busy_o  out  1  high while in RUN.
- done_o  out  1  one-cycle pulse on layer completion.
- skew_err_o  out  1  sticky; lanes disagreed after de-skew.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
  - While rst=1, all outputs go to 0 at the next clk edge.
  - Reset also clears the FSM to IDLE, clears all counters, and flushes the de-skew pipes.
  - A reset mid-layer abandons the layer: no done_o, no further writes.
- De-skew: lane i data and valid pass through a (PE_SIZE-1-i)-stage register pipe. Lane PE_SIZE-1 has zero stages. The pipes shift every cycle in every state.
- Aligned-row signals:
  - row_v = AND of all de-skewed valids.
  - row_any = OR of all de-skewed valids.
  - If row_any=1 and row_v=0 while in RUN, skew_err_o is set. It stays set until rst or the next accepted start_i; that row is not written.
- ReLU: when RELU_EN=1, each de-skewed lane with MSB=1 is replaced by 0. There is no other arithmetic; widths are unchanged.
- Write port: all mem2 outputs are registered.
  - In RUN with row_v=1: the next cycle has mem2_ce0=mem2_we0=1, mem2_d0 = the row, mem2_addr0 = wr_addr.
  - Otherwise ce0=we0=0; d0 and addr0 hold their last values.
  - Latency: lane-0 valid at cycle t gives the write at cycle t+PE_SIZE (ce0/we0 high during that cycle).
- Counters, updated per written row:
  - row_cnt: 0..ROW_NUM-1. Wraps to 0 and increments tile_cnt when it was ROW_NUM-1.
  - wr_addr: increments by 1 and wraps from MEM2_DEPTH-1 to 0.
- FSM:
  - IDLE: busy_o=0. start_i moves to RUN and clears row_cnt, tile_cnt, wr_addr and skew_err_o. Valid rows arriving in IDLE are dropped.
  - RUN: busy_o=1. Writes rows. start_i is ignored. When the row with tile_cnt=TILE_NUM-1 and row_cnt=ROW_NUM-1 is written, move to DONE.
  - DONE: done_o=1 for exactly one cycle (the cycle after the last write), busy_o=0, then move to IDLE. Valid rows arriving in DONE are dropped.
- Simultaneous events:
  - rst outranks everything.
  - start_i in the same cycle as the DONE→IDLE transition is ignored; it is honoured only when the FSM is in IDLE.

Test Plan:
- Single-tile smoke test, PE_SIZE=4, ROW_NUM=3, TILE_NUM=1.
  - Stimulus: start_i, then rows with correct skew (lane i valid i cycles after lane 0), values 1..12.
  - Required: 3 writes at addr 0,1,2, each lane-0 valid + 4 cycles later; d0 rows {4,3,2,1}, {8,7,6,5}, {12,11,10,9} (lane 3 in the MS byte, lane 0 in the LS byte); done_o one cycle after the third write; busy_o falls with it.
- Full layer with defaults.
  - Stimulus: 896 back-to-back skewed rows.
  - Required: 896 writes, addresses 0..895 in order; tile_cnt ends at 13; exactly one done_o; skew_err_o=0.
- ReLU.
  - Stimulus: lane values {-5, 7, -128, 127} with RELU_EN=1.
  - Required: write data {0, 7, 0, 127}.
  - Same stimulus with RELU_EN=0: data passes unchanged.
- Skew error.
  - Stimulus: lane 2 valid delayed 1 extra cycle.
  - Required: skew_err_o rises, that row is not written, row_cnt is unchanged, the next clean row goes to the same address, skew_err_o stays 1 until the next start_i.
- Start while busy / idle traffic.
  - Stimulus: valid rows sent in IDLE; start_i pulsed mid-RUN.
  - Required: no writes in IDLE; the mid-RUN start_i does not reset counters or the address.
- Reset mid-operation.
  - Stimulus: rst=1 for 1 cycle after 10 rows.
  - Required: at the next edge all outputs are 0 and the FSM is in IDLE; in-flight rows are not written; no done_o; a new start_i restarts writing at addr 0.

Source files
------------

// File: rtl/conv_result_writer.sv
// Write side of the conv data mover: de-skews systolic-array result rows,
// optionally clamps negatives to zero, and writes one row per mem2 address.
module conv_result_writer #(
    parameter int PE_SIZE         = 16,
    parameter int DATA_WIDTH      = 8,
    parameter int ROW_NUM         = 64,
    parameter int TILE_NUM        = 14,
    parameter int MEM2_DEPTH      = 896,
    parameter int MEM2_ADDR_WIDTH = 10,
    parameter int RELU_EN         = 1,
    localparam int MEM2_DATA_WIDTH = PE_SIZE * DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [MEM2_DATA_WIDTH-1:0] sa_result_i,
    input  logic [PE_SIZE-1:0]         sa_valid_i,
    output logic [MEM2_ADDR_WIDTH-1:0] mem2_addr0,
    output logic                       mem2_ce0,
    output logic                       mem2_we0,
    output logic [MEM2_DATA_WIDTH-1:0] mem2_d0,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       skew_err_o
);

    localparam int RC_W = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
    localparam int TC_W = (TILE_NUM > 1) ? $clog2(TILE_NUM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [RC_W-1:0]            row_cnt_q, row_cnt_d;
    logic [TC_W-1:0]            tile_cnt_q, tile_cnt_d;
    logic [MEM2_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                       skew_err_q, skew_err_d;
    logic                       wr_en_q, wr_en_d;
    logic [MEM2_ADDR_WIDTH-1:0] mem2_addr_q, mem2_addr_d;
    logic [MEM2_DATA_WIDTH-1:0] mem2_d_q, mem2_d_d;
    logic                       busy_q, done_q;

    logic [DATA_WIDTH-1:0]      lane_data_s [PE_SIZE];
    logic [PE_SIZE-1:0]         lane_valid_s;
    logic                       row_v_s, row_any_s;
    logic [MEM2_DATA_WIDTH-1:0] row_data_s;

    function automatic logic [DATA_WIDTH-1:0] relu_lane(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] y;
        if ((RELU_EN != 0) && x[DATA_WIDTH-1]) begin
            y = {DATA_WIDTH{1'b0}};
        end else begin
            y = x;
        end
        return y;
    endfunction

    // Lane i is i cycles late, so it is delayed by PE_SIZE-1-i stages to line up with the last lane.
    for (genvar i = 0; i < PE_SIZE; i++) begin : g_lane
        localparam int DEPTH = PE_SIZE - 1 - i;
        if (DEPTH == 0) begin : g_direct
            assign lane_data_s[i]  = sa_result_i[i*DATA_WIDTH +: DATA_WIDTH];
            assign lane_valid_s[i] = sa_valid_i[i];
        end else begin : g_pipe
            logic [DATA_WIDTH-1:0] data_q [DEPTH];
            logic [DEPTH-1:0]      valid_q;

            // Per-lane delay pipe; shifts every cycle regardless of FSM state.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < DEPTH; s++) begin
                        data_q[s] <= {DATA_WIDTH{1'b0}};
                    end
                    valid_q <= {DEPTH{1'b0}};
                end else begin
                    data_q[0]  <= sa_result_i[i*DATA_WIDTH +: DATA_WIDTH];
                    valid_q[0] <= sa_valid_i[i];
                    for (int s = 1; s < DEPTH; s++) begin
                        data_q[s]  <= data_q[s-1];
                        valid_q[s] <= valid_q[s-1];
                    end
                end
            end

            assign lane_data_s[i]  = data_q[DEPTH-1];
            assign lane_valid_s[i] = valid_q[DEPTH-1];
        end
    end

    assign row_v_s   = &lane_valid_s;
    assign row_any_s = |lane_valid_s;

    // Assemble the aligned row with lane 0 in the least significant slot.
    always_comb begin
        row_data_s = {MEM2_DATA_WIDTH{1'b0}};
        for (int i = 0; i < PE_SIZE; i++) begin
            row_data_s[i*DATA_WIDTH +: DATA_WIDTH] = relu_lane(lane_data_s[i]);
        end
    end

    // Next-state, counter and write-port logic.
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        tile_cnt_d  = tile_cnt_q;
        wr_addr_d   = wr_addr_q;
        skew_err_d  = skew_err_q;
        wr_en_d     = 1'b0;
        mem2_addr_d = mem2_addr_q;
        mem2_d_d    = mem2_d_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_RUN;
                    row_cnt_d  = {RC_W{1'b0}};
                    tile_cnt_d = {TC_W{1'b0}};
                    wr_addr_d  = {MEM2_ADDR_WIDTH{1'b0}};
                    skew_err_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (row_v_s) begin
                    wr_en_d     = 1'b1;
                    mem2_addr_d = wr_addr_q;
                    mem2_d_d    = row_data_s;
                    if (wr_addr_q == MEM2_ADDR_WIDTH'(MEM2_DEPTH - 1)) begin
                        wr_addr_d = {MEM2_ADDR_WIDTH{1'b0}};
                    end else begin
                        wr_addr_d = wr_addr_q + MEM2_ADDR_WIDTH'(1);
                    end
                    if (row_cnt_q == RC_W'(ROW_NUM - 1)) begin
                        row_cnt_d = {RC_W{1'b0}};
                        // The final tile holds its count so it reads TILE_NUM-1 after the layer.
                        if (tile_cnt_q == TC_W'(TILE_NUM - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            tile_cnt_d = tile_cnt_q + TC_W'(1);
                        end
                    end else begin
                        row_cnt_d = row_cnt_q + RC_W'(1);
                    end
                end else if (row_any_s) begin
                    skew_err_d = 1'b1;
                end else begin
                    skew_err_d = skew_err_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_cnt_q   <= {RC_W{1'b0}};
            tile_cnt_q  <= {TC_W{1'b0}};
            wr_addr_q   <= {MEM2_ADDR_WIDTH{1'b0}};
            skew_err_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            mem2_addr_q <= {MEM2_ADDR_WIDTH{1'b0}};
            mem2_d_q    <= {MEM2_DATA_WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            tile_cnt_q  <= tile_cnt_d;
            wr_addr_q   <= wr_addr_d;
            skew_err_q  <= skew_err_d;
            wr_en_q     <= wr_en_d;
            mem2_addr_q <= mem2_addr_d;
            mem2_d_q    <= mem2_d_d;
            busy_q      <= (state_q == ST_RUN);
            done_q      <= (state_q == ST_DONE);
        end
    end

    assign mem2_addr0 = mem2_addr_q;
    assign mem2_ce0   = wr_en_q;
    assign mem2_we0   = wr_en_q;
    assign mem2_d0    = mem2_d_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign skew_err_o = skew_err_q;

endmodule
